// File: rtl/a2d_sched_if.sv
// SPI transaction-engine handshake between the A2D scheduler (master) and the engine (slave).
// wrt starts a transaction; done returns its completion along with rd_data.
interface a2d_sched_if;
    logic        wrt;
    logic [15:0] wt_data;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, wt_data, input done, rd_data);
    modport slave  (input wrt, wt_data, output done, rd_data);
endinterface

// File: rtl/a2d_sched.sv
// Round-robin plus on-demand battery scheduler for two-transaction A2D conversions.
// A conversion starts one clock after a request is pending; results and upd appear one clock after the final done.
module a2d_sched #(
    parameter int          PERIOD   = 1024,
    parameter int          GAP      = 2,
    parameter logic [2:0]  CH_LFT   = 3'd0,
    parameter logic [2:0]  CH_RGHT  = 3'd4,
    parameter logic [2:0]  CH_STEER = 3'd5,
    parameter logic [2:0]  CH_BATT  = 3'd6
) (
    input  logic              clk,
    input  logic              rst,
    a2d_sched_if.master       spi,
    input  logic              en_i,
    input  logic              batt_req_i,
    output logic [11:0]       lft_ld_o,
    output logic [11:0]       rght_ld_o,
    output logic [11:0]       steer_pot_o,
    output logic [11:0]       batt_o,
    output logic [3:0]        upd_o,
    output logic              batt_ack_o,
    output logic              busy_o
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {IDLE, CMD, WAIT1, GAPW, RD, WAIT2} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              slot_pend_q, slot_pend_d;
    logic              batt_pend_q, batt_pend_d;
    logic [1:0]        ptr_q, sel_q, sel_d;
    logic              slot_cv_q, batt_cv_q;
    logic [GW-1:0]     gcnt_q;
    logic              wrt_q, busy_q, batt_ack_q;
    logic [15:0]       wt_data_q;
    logic [3:0][11:0]  res_q;
    logic [3:0]        upd_q;
    logic              slot_tick, take_batt, take_slot;

    // Slot indices 0..3 map to LFT, RGHT, STEER, BATT; index 3 doubles as the battery slot.
    function automatic logic [2:0] ch_of(input logic [1:0] idx);
        case (idx)
            2'd0:    ch_of = CH_LFT;
            2'd1:    ch_of = CH_RGHT;
            2'd2:    ch_of = CH_STEER;
            default: ch_of = CH_BATT;
        endcase
    endfunction

    always_comb begin
        cnt_d     = '0;
        slot_tick = 1'b0;
        if (en_i) begin
            if (cnt_q == CW'(PERIOD - 1)) slot_tick = 1'b1;
            else                          cnt_d     = cnt_q + CW'(1);
        end
        // Battery wins; a pending slot rides along only when it is the battery's own turn.
        take_batt   = (state_q == IDLE) && batt_pend_q;
        take_slot   = (state_q == IDLE) && slot_pend_q && en_i && (!batt_pend_q || ptr_q == 2'd3);
        sel_d       = take_batt ? 2'd3 : ptr_q;
        slot_pend_d = en_i && ((slot_pend_q && !take_slot) || slot_tick);
        batt_pend_d = (batt_pend_q && !take_batt) || batt_req_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            slot_pend_q <= 1'b0;
            batt_pend_q <= 1'b0;
            ptr_q       <= 2'd0;
            sel_q       <= 2'd0;
            slot_cv_q   <= 1'b0;
            batt_cv_q   <= 1'b0;
            gcnt_q      <= '0;
            wrt_q       <= 1'b0;
            busy_q      <= 1'b0;
            batt_ack_q  <= 1'b0;
            wt_data_q   <= '0;
            res_q       <= '0;
            upd_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            slot_pend_q <= slot_pend_d;
            batt_pend_q <= batt_pend_d;
            wrt_q       <= 1'b0;
            upd_q       <= '0;
            batt_ack_q  <= 1'b0;
            case (state_q)
                IDLE: if (take_batt || take_slot) begin
                    state_q   <= CMD;
                    wrt_q     <= 1'b1;
                    busy_q    <= 1'b1;
                    sel_q     <= sel_d;
                    slot_cv_q <= take_slot;
                    batt_cv_q <= take_batt;
                    wt_data_q <= {2'b00, ch_of(sel_d), 11'h000};
                end
                CMD:   state_q <= WAIT1;
                WAIT1: if (spi.done) begin
                    state_q <= GAPW;
                    gcnt_q  <= '0;
                end
                GAPW: if (gcnt_q == GW'(GAP - 1)) begin
                    state_q <= RD;
                    wrt_q   <= 1'b1;
                end else begin
                    gcnt_q  <= gcnt_q + GW'(1);
                end
                RD:    state_q <= WAIT2;
                WAIT2: if (spi.done) begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    res_q[sel_q] <= spi.rd_data[11:0];
                    upd_q        <= 4'(1) << sel_q;
                    batt_ack_q   <= batt_cv_q;
                    if (slot_cv_q) ptr_q <= ptr_q + 2'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi.wrt     = wrt_q;
    assign spi.wt_data = wt_data_q;
    assign lft_ld_o    = res_q[0];
    assign rght_ld_o   = res_q[1];
    assign steer_pot_o = res_q[2];
    assign batt_o      = res_q[3];
    assign upd_o       = upd_q;
    assign batt_ack_o  = batt_ack_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_a2d_sched.sv
// Scoreboard bench for a2d_sched: a transaction-level model predicts each conversion, a monitor checks it.
module tb_a2d_sched;
    localparam int P    = 16;
    localparam int G    = 2;
    localparam int L    = 3;            // SPI stub: done arrives L cycles after each wrt
    localparam int CONV = 3 + 2*L + G;  // cycles from the deciding IDLE cycle until IDLE again

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, batt_req = 1'b0;
    logic [11:0] lft, rght, steer, batt;
    logic [3:0]  upd;
    logic        batt_ack, busy;

    a2d_sched_if spi ();

    a2d_sched #(.PERIOD(P), .GAP(G)) dut (
        .clk(clk), .rst(rst), .spi(spi), .en_i(en), .batt_req_i(batt_req),
        .lft_ld_o(lft), .rght_ld_o(rght), .steer_pot_o(steer), .batt_o(batt),
        .upd_o(upd), .batt_ack_o(batt_ack), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] word; int idx; bit ack; int cmd; } conv_t;
    conv_t       q[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, m_free = 0, m_cnt = 0, m_ptr = 0;
    bit          m_slot = 0, m_batt = 0;
    int          ph = 0, t1 = 0, t2 = 0, dcnt = 0;
    bit          spur = 0;
    logic [11:0] m_res [4];

    function automatic logic [15:0] word_of(input int idx);
        case (idx)
            0:       return 16'h0000;
            1:       return 16'h2000;
            2:       return 16'h2800;
            default: return 16'h3000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bad(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got event, expected none (cycle %0d)", nm, cyc);
    endtask

    // Reference model: pending flags, pointer and a busy-until time, advanced once per clock.
    always @(posedge clk) begin : model
        bit idle, tb_, ts_, tick;
        if (rst) begin
            m_cnt = 0; m_slot = 0; m_batt = 0; m_ptr = 0; m_free = 0;
            q.delete();
        end else begin
            idle  = (cyc >= m_free);
            tb_   = idle && m_batt;
            ts_   = idle && m_slot && en && (!m_batt || m_ptr == 3);
            tick  = en && (m_cnt == P - 1);
            m_cnt = (en && !tick) ? m_cnt + 1 : 0;
            if (tb_ || ts_) begin
                q.push_back('{word_of(tb_ ? 3 : m_ptr), tb_ ? 3 : m_ptr, tb_, cyc + 1});
                if (ts_) m_ptr = (m_ptr + 1) % 4;
                m_free = cyc + CONV;
            end
            m_slot = en && ((m_slot && !ts_) || tick);
            m_batt = (m_batt && !tb_) || batt_req;
        end
        cyc++;
    end

    // SPI engine stub, with optional stray done pulses while nothing is in flight.
    always @(negedge clk) begin
        spi.done = 1'b0;
        if (rst) dcnt = 0;
        else begin
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin spi.done = 1'b1; spi.rd_data = 16'($urandom); end
            end
            if (spi.wrt) dcnt = L;
            if (spur && dcnt == 0 && !spi.done) begin spi.done = 1'b1; spi.rd_data = 16'($urandom); end
        end
    end

    always @(negedge clk) begin : monitor
        if (rst) begin
            ph = 0;
            for (int i = 0; i < 4; i++) m_res[i] = '0;
        end else begin
            chk("busy", busy, cyc < m_free);
            if (spi.wrt) begin
                if (q.size() == 0 || ph == 2) bad("unexpected_wrt");
                else if (ph == 0) begin
                    chk("cmd_word", spi.wt_data, q[0].word);
                    chk("cmd_cycle", cyc, q[0].cmd);
                    t1 = cyc; ph = 1;
                end else begin
                    chk("rd_word", spi.wt_data, q[0].word);
                    chk("rd_cycle", cyc, t1 + L + G + 1);
                    t2 = cyc; ph = 2;
                end
            end
            if (upd != 0 || batt_ack) begin
                if (ph != 2) bad("unexpected_upd");
                else begin
                    chk("upd_cycle", cyc, t2 + L + 1);
                    chk("upd", upd, 4'b0001 << q[0].idx);
                    chk("batt_ack", batt_ack, q[0].ack);
                    m_res[q[0].idx] = spi.rd_data[11:0];
                    chk("results", {lft, rght, steer, batt}, {m_res[0], m_res[1], m_res[2], m_res[3]});
                    void'(q.pop_front());
                    ph = 0;
                end
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_wrt"}, spi.wrt, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_results"}, {lft, rght, steer, batt}, 48'h0);
        chk({tag, "_upd_ack"}, {upd, batt_ack}, 5'h0);
    endtask

    initial begin
        bit found;
        tick_n(3);
        reset_checks("reset");
        chk("reset_wt_data", spi.wt_data, 16'h0000);
        @(posedge clk); #2 rst = 1'b0;

        // Round-robin slots through two full wraps.
        tick_n(1); en = 1'b1;
        tick_n(8 * P + 10);

        // Random battery requests and occasional en toggles.
        for (int i = 0; i < 800; i++) begin
            tick_n(1);
            batt_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) en = ~en;
        end
        batt_req = 1'b0; en = 1'b1;

        // batt_req during WAIT2 of a LFT slot conversion.
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick_n(1);
            if (ph == 2 && q.size() > 0 && q[0].idx == 0 && !q[0].ack) found = 1;
        end
        if (!found) bad("timeout_lft_wait2");
        batt_req = 1'b1; tick_n(1); batt_req = 1'b0;
        tick_n(3 * P);

        // Pointer at BATT with slot and battery requests pending together.
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick_n(1);
            if (m_ptr == 3 && m_cnt == P - 1 && cyc >= m_free && !m_batt && !m_slot) found = 1;
        end
        if (!found) bad("timeout_ptr_batt");
        batt_req = 1'b1; tick_n(1); batt_req = 1'b0;
        tick_n(3 * P);

        // en low: one on-demand battery conversion, then silence even with stray done pulses.
        en = 1'b0;
        tick_n(2 * CONV);
        batt_req = 1'b1; tick_n(1); batt_req = 1'b0;
        tick_n(2 * CONV);
        spur = 1'b1; tick_n(6); spur = 1'b0;
        tick_n(P + 4);

        // Reset during WAIT2, then the first slot after release must be LFT.
        en = 1'b1;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick_n(1);
            if (ph == 2) found = 1;
        end
        if (!found) bad("timeout_wait2_for_reset");
        @(posedge clk); #2 rst = 1'b1;
        #1 reset_checks("midrst");
        tick_n(2);
        reset_checks("midrst_hold");
        @(posedge clk); #2 rst = 1'b0;
        tick_n(P + 2 * CONV);

        en = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick_n(1);
            if (q.size() == 0 && cyc >= m_free) found = 1;
        end
        chk("drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
